// File: rtl/imem_loader.sv
// Byte-stream instruction-memory loader: reads a 16-bit word count, then packs little-endian bytes into 32-bit writes.
// Optional trailing XOR checksum byte is enabled by defining IMEM_LOADER_CSUM_EN.
module imem_loader #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              core_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN0 = 3'd1,
        LEN1 = 3'd2,
        DATA = 3'd3,
`ifdef IMEM_LOADER_CSUM_EN
        CSUM = 3'd4,
`endif
        DONE = 3'd5,
        ERR  = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic              accept;
    logic              start_take;
    logic              last_byte;
    logic              last_word;
    logic              len_bad;
    logic [15:0]       len_n;
    logic [7:0]        len_lo_q;
    logic [ADDR_W:0]   len_q;
    logic [1:0]        lane_q;
    logic [23:0]       asm_q;
`ifdef IMEM_LOADER_CSUM_EN
    logic [7:0]        csum_q;
`endif

    assign accept     = in_valid && in_ready;
    assign start_take = start && ((state_q == IDLE) || (state_q == DONE) || (state_q == ERR));
    assign len_n      = {in_data, len_lo_q};
    assign len_bad    = (len_n == 16'd0) || (32'(len_n) > DEPTH);
    assign last_byte  = (lane_q == 2'd3);
    // words_loaded still holds k when word k's final byte arrives.
    assign last_word  = ((words_loaded + (ADDR_W+1)'(1)) == len_q);

    // NOTE: reset here is synchronous, so rst sits inside the clocked block rather than in its sensitivity list.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d gets a default before the case so no path leaves it unassigned and a latch cannot be inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE, ERR: if (start) state_d = LEN0;
            LEN0:            if (accept) state_d = LEN1;
            LEN1:            if (accept) state_d = len_bad ? ERR : DATA;
            DATA: begin
                if (accept && last_byte && last_word) begin
`ifdef IMEM_LOADER_CSUM_EN
                    state_d = CSUM;
`else
                    state_d = DONE;
`endif
                end
            end
`ifdef IMEM_LOADER_CSUM_EN
            CSUM:            if (accept) state_d = (in_data == csum_q) ? DONE : ERR;
`endif
            default:         state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        core_hold = 1'b0;
        done      = 1'b0;
        error     = 1'b0;
        case (state_q)
            LEN0, LEN1, DATA: begin
                in_ready  = 1'b1;
                core_hold = 1'b1;
            end
`ifdef IMEM_LOADER_CSUM_EN
            CSUM: begin
                in_ready  = 1'b1;
                core_hold = 1'b1;
            end
`endif
            DONE:    done = 1'b1;
            ERR: begin
                error     = 1'b1;
                core_hold = 1'b1;
            end
            default: ;
        endcase
    end

    // NOTE: all datapath state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            words_loaded <= '0;
            len_lo_q     <= '0;
            len_q        <= '0;
            lane_q       <= '0;
            asm_q        <= '0;
`ifdef IMEM_LOADER_CSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            wr_en <= 1'b0;
            if (start_take) begin
                words_loaded <= '0;
                lane_q       <= '0;
`ifdef IMEM_LOADER_CSUM_EN
                csum_q       <= '0;
`endif
            end else if (accept) begin
                case (state_q)
                    LEN0: len_lo_q <= in_data;
                    LEN1: len_q    <= len_n[ADDR_W:0];
                    DATA: begin
                        lane_q <= lane_q + 2'd1;
`ifdef IMEM_LOADER_CSUM_EN
                        csum_q <= csum_q ^ in_data;
`endif
                        case (lane_q)
                            2'd0: asm_q[7:0]   <= in_data;
                            2'd1: asm_q[15:8]  <= in_data;
                            2'd2: asm_q[23:16] <= in_data;
                            default: begin
                                wr_en        <= 1'b1;
                                wr_addr      <= words_loaded[ADDR_W-1:0];
                                wr_data      <= {in_data, asm_q};
                                words_loaded <= words_loaded + (ADDR_W+1)'(1);
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have parameter DEPTH, default 1024, meaning instruction-memory depth in 32-bit words.
REQ-002 The block SHALL have parameter ADDR_W, default 10, meaning word-address width (clog2 DEPTH).
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  one-cycle pulse that begins a load session.
REQ-006 in_valid  input  1  byte-stream valid.
REQ-007 in_data  input  8  byte-stream payload.
REQ-008 in_ready  output  1  byte-stream ready; a byte is accepted when in_valid && in_ready.
REQ-009 wr_en  output  1  instruction-memory write strobe, one cycle per word.
REQ-010 wr_addr  output  ADDR_W  instruction-memory word address.
REQ-011 wr_data  output  32  instruction word.
REQ-012 core_hold  output  1  holds the fetch stage stalled while a load is in progress.
REQ-013 done  output  1  level: last session completed successfully.
REQ-014 error  output  1  level: last session aborted.
REQ-015 words_loaded  output  ADDR_W+1  count of words written in the current or last session.

Function
REQ-016 States SHALL be IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERR.
REQ-017 The FSM SHALL go IDLE/DONE/ERR -> LEN0 on start; it SHALL ignore start in every other state.
REQ-018 Taking start SHALL clear done, error, words_loaded and the byte lane counter.
REQ-019 in_ready SHALL be 1 in LEN0, LEN1, DATA and CSUM, and 0 otherwise.
REQ-020 LEN0 SHALL accept the low byte and LEN1 the high byte of the 16-bit word count N, then go to DATA.
REQ-021 If N == 0 or N > DEPTH at LEN1 acceptance, the FSM SHALL go to ERR and write nothing.
REQ-022 DATA SHALL assemble bytes little-endian: first byte to [7:0], fourth to [31:24].
REQ-023 On acceptance of the 4th byte of word k, the block SHALL pulse wr_en for exactly one cycle on the next cycle, with wr_addr = k and wr_data = the assembled word; words_loaded SHALL increment in that same cycle.
REQ-024 Word addresses SHALL start at 0 and increment by 1; no wrap occurs because N <= DEPTH.
REQ-025 After word N-1 is written, the FSM SHALL go to CSUM if IMEM_LOADER_CSUM_EN is defined, else to DONE.
REQ-026 in_valid gaps SHALL stall progress without losing partial-word state.
REQ-027 core_hold SHALL be 1 in LEN0, LEN1, DATA, CSUM and ERR, and 0 in IDLE and DONE.
REQ-028 done SHALL be 1 only in DONE; error SHALL be 1 only in ERR.
REQ-029 DONE and ERR SHALL be held until the next start or rst.
REQ-030 wr_en SHALL never assert outside DATA or the cycle following the final DATA byte.

Reset
REQ-031 On rst the FSM SHALL enter IDLE, and the block SHALL drive in_ready=0, wr_en=0, wr_addr=0, wr_data=0, core_hold=0, done=0, error=0, words_loaded=0, and checksum accumulator=0.
REQ-032 rst mid-session SHALL abandon the session immediately; any pending wr_en SHALL be suppressed, and words already written SHALL remain in memory.
REQ-033 rst SHALL take priority over start in the same cycle.

Configuration
REQ-034 Macro IMEM_LOADER_CSUM_EN: when defined, the block SHALL keep a running XOR of all DATA bytes; CSUM SHALL accept one byte and go to DONE if it equals the XOR, else to ERR (words stay written).
REQ-035 Without IMEM_LOADER_CSUM_EN, the CSUM state and accumulator SHALL be absent and DATA SHALL go directly to DONE.

Verification
REQ-036 start; bytes 02 00, 93 00 31 00, 13 81 40 00 with in_valid held high -> wr_en twice: addr0=00310093, addr1=00408113; done=1, core_hold=0, words_loaded=2.
REQ-037 Same stream with in_valid toggling every other cycle -> identical writes and final state; in_ready stays 1 throughout.
REQ-038 Length bytes 00 00, then a second session with length 01 04 (N=1025) -> error=1, core_hold=1, no wr_en, in_ready=0 in both cases.
REQ-039 rst asserted after 2 of 4 data bytes, then a new start and a full 1-word load of 13 00 00 00 -> addr0=00000013, done=1, no stale partial bytes.
REQ-040 With IMEM_LOADER_CSUM_EN: N=1, data 33 81 20 00, checksum 92 -> done=1; with checksum 00 -> error=1 and the word is still written.
